// File: rtl/com_host_pkg.sv
// Shared encodings for the host sequencer: the status codes seen by the core-side
// selector and the sequencer state enum.
package com_host_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_LOAD = 2'b01;
  localparam logic [1:0] ST_RUN  = 2'b10;
  localparam logic [1:0] ST_READ = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LDRAIN,
    S_RUN,
    S_RD_ADDR,
    S_RD_CAP,
    S_RD_OUT,
    S_DONE
  } state_e;

  function automatic logic [1:0] status_of(input state_e s);
    case (s)
      S_LOAD, S_LDRAIN:               status_of = ST_LOAD;
      S_RUN:                          status_of = ST_RUN;
      S_RD_ADDR, S_RD_CAP, S_RD_OUT:  status_of = ST_READ;
      default:                        status_of = ST_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/com_host_ctrl.sv
// Host-end sequencer: streams a data image into core data memory, runs the core
// with a timeout, then streams a result window back out.
module com_host_ctrl
  import com_host_pkg::*;
#(
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] load_count,
  input  logic [15:0] read_base,
  input  logic [15:0] read_count,
  input  logic [15:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  status,
  output logic [15:0] com_data_in,
  output logic [15:0] com_addr,
  output logic        com_wr_en,
  input  logic [15:0] com_data_out,
  input  logic        end_process,
  output logic        busy,
  output logic        done,
  output logic        timeout_err
);

  localparam logic [31:0] RUN_LAST = 32'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] index_q, index_d;
  logic [15:0] load_cnt_q, load_cnt_d;
  logic [15:0] read_base_q, read_base_d;
  logic [15:0] read_cnt_q, read_cnt_d;
  logic [31:0] run_cnt_q, run_cnt_d;
  logic        timeout_err_q, timeout_err_d;
  logic [1:0]  status_q, status_d;
  logic [15:0] com_addr_q, com_addr_d;
  logic [15:0] com_data_in_q, com_data_in_d;
  logic        com_wr_en_q, com_wr_en_d;
  logic [15:0] out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        done_q, done_d;

  always_comb begin
    state_d       = state_q;
    index_d       = index_q;
    load_cnt_d    = load_cnt_q;
    read_base_d   = read_base_q;
    read_cnt_d    = read_cnt_q;
    run_cnt_d     = 32'd0;
    timeout_err_d = timeout_err_q;
    com_wr_en_d   = 1'b0;
    com_addr_d    = com_addr_q;
    com_data_in_d = com_data_in_q;
    out_data_d    = out_data_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          load_cnt_d    = load_count;
          read_base_d   = read_base;
          read_cnt_d    = read_count;
          index_d       = 16'd0;
          timeout_err_d = 1'b0;
          state_d       = (load_count != 16'd0) ? S_LOAD : S_RUN;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          com_wr_en_d   = 1'b1;
          com_addr_d    = index_q;
          com_data_in_d = in_data;
          index_d       = index_q + 16'd1;
          if (index_q == load_cnt_q - 16'd1) state_d = S_LDRAIN;
        end
      end
      // Lets the last registered write land before status flips to RUN.
      S_LDRAIN: state_d = S_RUN;
      S_RUN: begin
        run_cnt_d = run_cnt_q + 32'd1;
        if (end_process) begin
          index_d = 16'd0;
          state_d = (read_cnt_q == 16'd0) ? S_DONE : S_RD_ADDR;
        end else if (run_cnt_q == RUN_LAST) begin
          timeout_err_d = 1'b1;
          state_d       = S_DONE;
        end
      end
      S_RD_ADDR: state_d = S_RD_CAP;
      S_RD_CAP: begin
        out_data_d = com_data_out;
        state_d    = S_RD_OUT;
      end
      S_RD_OUT: begin
        if (out_ready) begin
          index_d = index_q + 16'd1;
          state_d = (index_q == read_cnt_q - 16'd1) ? S_DONE : S_RD_ADDR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Address is presented during RD_ADDR so memory data is ready in RD_CAP.
    if (state_d == S_RD_ADDR) com_addr_d = read_base_q + index_d;

    status_d    = status_of(state_d);
    out_valid_d = (state_d == S_RD_OUT);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      index_q       <= 16'd0;
      load_cnt_q    <= 16'd0;
      read_base_q   <= 16'd0;
      read_cnt_q    <= 16'd0;
      run_cnt_q     <= 32'd0;
      timeout_err_q <= 1'b0;
      status_q      <= ST_IDLE;
      com_addr_q    <= 16'd0;
      com_data_in_q <= 16'd0;
      com_wr_en_q   <= 1'b0;
      out_data_q    <= 16'd0;
      out_valid_q   <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      index_q       <= index_d;
      load_cnt_q    <= load_cnt_d;
      read_base_q   <= read_base_d;
      read_cnt_q    <= read_cnt_d;
      run_cnt_q     <= run_cnt_d;
      timeout_err_q <= timeout_err_d;
      status_q      <= status_d;
      com_addr_q    <= com_addr_d;
      com_data_in_q <= com_data_in_d;
      com_wr_en_q   <= com_wr_en_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      done_q        <= done_d;
    end
  end

  assign in_ready    = (state_q == S_LOAD);
  assign busy        = (state_q != S_IDLE);
  assign status      = status_q;
  assign com_addr    = com_addr_q;
  assign com_data_in = com_data_in_q;
  assign com_wr_en   = com_wr_en_q;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign done        = done_q;
  assign timeout_err = timeout_err_q;

endmodule
